// File: rtl/pulse_train_module_pkg.sv
// Shared definitions for the pulse train generator: FSM state encodings,
// register-bank command codes and default field widths.
package pulse_train_module_pkg;

  // Default field widths used when the top is instantiated without overrides
  localparam int PT_WIDTH_BITS_DEFAULT = 24;
  localparam int PT_COUNT_BITS_DEFAULT = 8;

  // Register-bank command codes decoded by the clk_usb wrapper
  localparam logic [7:0] PULSE_TRAIN_WIDTH  = 8'h40;
  localparam logic [7:0] PULSE_TRAIN_GAP    = 8'h41;
  localparam logic [7:0] PULSE_TRAIN_COUNT  = 8'h42;
  localparam logic [7:0] PULSE_TRAIN_ENABLE = 8'h43;

  // FSM state encodings; the value is exported on debug[1:0]
  typedef enum logic [1:0] {
    STATE_PT_IDLE = 2'd0,
    STATE_PT_HIGH = 2'd1,
    STATE_PT_GAP  = 2'd2,
    STATE_PT_DONE = 2'd3
  } pt_state_e;

endpackage

// File: rtl/pulse_train_module_edge_detect.sv
// Registered rising-edge detector for the trigger strobe. An edge is only
// reported once the input has been seen low after reset, so a level held
// high across reset release cannot start a train by itself.
module pt_edge_detect (
  input  logic clk_i,
  input  logic reset_i,
  input  logic enable_i,
  input  logic trigger_i,
  output logic rise_o
);

  logic trig_q;
  logic armed_q;

  // Track the previous trigger level and arm once a low level has been seen
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      trig_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      trig_q  <= trigger_i;
      armed_q <= armed_q | ~trigger_i;
    end
  end

  assign rise_o = trigger_i & ~trig_q & armed_q & enable_i;

endmodule

// File: rtl/pulse_train_module.sv
// Pulse train generator: on a qualified trigger edge, emits pulse_count
// pulses of pulse_width high cycles separated by pulse_gap low cycles,
// then a one-cycle done strobe. Configuration is shadowed at start.
module pulse_train_module
  import pulse_train_module_pkg::*;
#(
  parameter int WIDTH_BITS = PT_WIDTH_BITS_DEFAULT,
  parameter int COUNT_BITS = PT_COUNT_BITS_DEFAULT
) (
  input  logic                  timerclk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  trigger_in,
  input  logic [WIDTH_BITS-1:0] pulse_width,
  input  logic [WIDTH_BITS-1:0] pulse_gap,
  input  logic [COUNT_BITS-1:0] pulse_count,
  output logic                  pulse_out,
  output logic                  busy,
  output logic                  done,
  output logic [COUNT_BITS-1:0] pulse_idx,
  output logic [3:0]            debug
);

  localparam logic [WIDTH_BITS-1:0] W_ZERO = {WIDTH_BITS{1'b0}};
  localparam logic [WIDTH_BITS-1:0] W_ONE  = {{(WIDTH_BITS-1){1'b0}}, 1'b1};
  localparam logic [COUNT_BITS-1:0] C_ZERO = {COUNT_BITS{1'b0}};
  localparam logic [COUNT_BITS-1:0] C_ONE  = {{(COUNT_BITS-1){1'b0}}, 1'b1};

  // A zero width or gap behaves as one cycle, so counters never wrap
  function automatic logic [WIDTH_BITS-1:0] floor_one(input logic [WIDTH_BITS-1:0] v);
    floor_one = (v == W_ZERO) ? W_ONE : v;
  endfunction

  pt_state_e             state_q;
  logic [WIDTH_BITS-1:0] cnt_q;
  logic [WIDTH_BITS-1:0] w_sh_q;
  logic [WIDTH_BITS-1:0] g_sh_q;
  logic [COUNT_BITS-1:0] idx_last_q;
  logic [COUNT_BITS-1:0] idx_q;
  logic                  pulse_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  edge_q;
  logic                  abort_q;

  logic                  rise_s;
  logic                  start_s;
  logic [WIDTH_BITS-1:0] w_eff_d;
  logic                  last_pulse_s;

  pt_edge_detect u_edge (
    .clk_i     (timerclk),
    .reset_i   (reset),
    .enable_i  (enable),
    .trigger_i (trigger_in),
    .rise_o    (rise_s)
  );

  // Edges while a train is running (including the DONE cycle) are dropped
  assign start_s      = rise_s & (pulse_count != C_ZERO) & (state_q == STATE_PT_IDLE);
  assign w_eff_d      = floor_one(pulse_width);
  assign last_pulse_s = (idx_q == idx_last_q);

  // Train sequencer: state, counters, shadow registers and registered outputs
  always_ff @(posedge timerclk) begin
    if (reset) begin
      state_q    <= STATE_PT_IDLE;
      cnt_q      <= W_ZERO;
      w_sh_q     <= W_ONE;
      g_sh_q     <= W_ONE;
      idx_last_q <= C_ZERO;
      idx_q      <= C_ZERO;
      pulse_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      edge_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      edge_q <= rise_s;
      if ((state_q != STATE_PT_IDLE) && !enable) begin
        // Abort: drop everything immediately, no done strobe
        state_q <= STATE_PT_IDLE;
        pulse_q <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
        abort_q <= 1'b1;
      end else begin
        case (state_q)
          STATE_PT_IDLE: begin
            done_q <= 1'b0;
            if (start_s) begin
              state_q    <= STATE_PT_HIGH;
              w_sh_q     <= w_eff_d;
              g_sh_q     <= floor_one(pulse_gap);
              idx_last_q <= pulse_count - C_ONE;
              cnt_q      <= w_eff_d - W_ONE;
              idx_q      <= C_ZERO;
              pulse_q    <= 1'b1;
              busy_q     <= 1'b1;
              abort_q    <= 1'b0;
            end else begin
              pulse_q <= 1'b0;
              busy_q  <= 1'b0;
            end
          end
          STATE_PT_HIGH: begin
            if (cnt_q == W_ZERO) begin
              pulse_q <= 1'b0;
              if (last_pulse_s) begin
                // No trailing gap after the final pulse
                state_q <= STATE_PT_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= STATE_PT_GAP;
                cnt_q   <= g_sh_q - W_ONE;
              end
            end else begin
              cnt_q <= cnt_q - W_ONE;
            end
          end
          STATE_PT_GAP: begin
            if (cnt_q == W_ZERO) begin
              state_q <= STATE_PT_HIGH;
              pulse_q <= 1'b1;
              cnt_q   <= w_sh_q - W_ONE;
              idx_q   <= last_pulse_s ? idx_q : (idx_q + C_ONE);
            end else begin
              cnt_q <= cnt_q - W_ONE;
            end
          end
          STATE_PT_DONE: begin
            state_q <= STATE_PT_IDLE;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
          default: begin
            state_q <= STATE_PT_IDLE;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pulse_idx = idx_q;
  assign debug     = {abort_q, edge_q, state_q};

endmodule

// File: tb/tb_pulse_train_module.sv
// Self-checking bench for pulse_train_module: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a queue-based model
// that expands each train into its expected per-cycle waveform.
module tb_pulse_train_module;

  localparam int WB = 24;
  localparam int CB = 8;

  logic          timerclk = 1'b0;
  logic          reset;
  logic          enable;
  logic          trigger_in;
  logic [WB-1:0] pulse_width;
  logic [WB-1:0] pulse_gap;
  logic [CB-1:0] pulse_count;
  logic          pulse_out;
  logic          busy;
  logic          done;
  logic [CB-1:0] pulse_idx;
  logic [3:0]    debug;

  int checks_cnt = 0;
  int errors_cnt = 0;

  always #5 timerclk = ~timerclk;

  pulse_train_module #(.WIDTH_BITS(WB), .COUNT_BITS(CB)) dut (
    .timerclk    (timerclk),
    .reset       (reset),
    .enable      (enable),
    .trigger_in  (trigger_in),
    .pulse_width (pulse_width),
    .pulse_gap   (pulse_gap),
    .pulse_count (pulse_count),
    .pulse_out   (pulse_out),
    .busy        (busy),
    .done        (done),
    .pulse_idx   (pulse_idx),
    .debug       (debug)
  );

  typedef struct {
    bit p;
    bit b;
    bit d;
    int idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   m_prev;
  bit   m_armed;
  bit   m_abort;
  int   st_high;
  int   st_busy;
  int   st_done;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks_cnt++;
    if (obs !== expv) begin
      errors_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  // Expand a whole train into per-cycle expected outputs
  task automatic build_train(input int w, input int g, input int n);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < w; c++) exp_q.push_back('{p: 1'b1, b: 1'b1, d: 1'b0, idx: k});
      if (k < n - 1)
        for (int c = 0; c < g; c++) exp_q.push_back('{p: 1'b0, b: 1'b1, d: 1'b0, idx: k});
    end
    exp_q.push_back('{p: 1'b0, b: 1'b1, d: 1'b1, idx: n - 1});
  endtask

  // Advance the model by one clock using the inputs presented at this edge
  task automatic model_step();
    exp_t nxt;
    nxt = '{p: 1'b0, b: 1'b0, d: 1'b0, idx: cur.idx};
    if (reset) begin
      exp_q.delete();
      m_prev  = 1'b0;
      m_armed = 1'b0;
      m_abort = 1'b0;
      nxt.idx = 0;
    end else begin
      if (cur.b && !enable) begin
        exp_q.delete();
        m_abort = 1'b1;
      end else if (cur.b) begin
        if (exp_q.size() > 0) nxt = exp_q.pop_front();
      end else if (trigger_in && !m_prev && m_armed && enable && (pulse_count != 0)) begin
        build_train(eff(int'(pulse_width)), eff(int'(pulse_gap)), int'(pulse_count));
        nxt     = exp_q.pop_front();
        m_abort = 1'b0;
      end
      m_prev = trigger_in;
      if (!trigger_in) m_armed = 1'b1;
    end
    cur = nxt;
  endtask

  task automatic tick();
    int st;
    @(posedge timerclk);
    model_step();
    #1;
    st = !cur.b ? 0 : (cur.d ? 3 : (cur.p ? 1 : 2));
    check_value("pulse_out", 32'(pulse_out), 32'(cur.p));
    check_value("busy", 32'(busy), 32'(cur.b));
    check_value("done", 32'(done), 32'(cur.d));
    check_value("pulse_idx", 32'(pulse_idx), cur.idx);
    check_value("abort_flag", 32'(debug[3]), 32'(m_abort));
    check_value("state", 32'(debug[1:0]), st);
    st_high += int'(pulse_out);
    st_busy += int'(busy);
    st_done += int'(done);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr_stats();
    st_high = 0;
    st_busy = 0;
    st_done = 0;
  endtask

  task automatic edge_trigger();
    trigger_in = 1'b0;
    tick();
    trigger_in = 1'b1;
    tick();
  endtask

  task automatic set_cfg(input int w, input int g, input int n);
    pulse_width = WB'(w);
    pulse_gap   = WB'(g);
    pulse_count = CB'(n);
  endtask

  initial begin
    cur = '{p: 1'b0, b: 1'b0, d: 1'b0, idx: 0};
    m_prev = 1'b0; m_armed = 1'b0; m_abort = 1'b0;
    clr_stats();
    reset = 1'b1; enable = 1'b1; trigger_in = 1'b0;
    set_cfg(3, 2, 2);
    ticks(3);
    check_value("reset_debug", 32'(debug), 32'd0);
    reset = 1'b0;

    // W=3 G=2 N=2: 2 pulses of 3, busy 3+2+3+1
    ticks(6);
    clr_stats();
    trigger_in = 1'b1;
    ticks(15);
    check_value("t1_high", st_high, 32'd6);
    check_value("t1_busy", st_busy, 32'd9);
    check_value("t1_done", st_done, 32'd1);

    // W=0 G=0 N=3: three single-cycle pulses
    set_cfg(0, 0, 3);
    clr_stats();
    edge_trigger();
    ticks(10);
    check_value("t2_high", st_high, 32'd3);
    check_value("t2_busy", st_busy, 32'd6);
    check_value("t2_done", st_done, 32'd1);

    // N=0: edge ignored entirely
    set_cfg(4, 4, 0);
    clr_stats();
    edge_trigger();
    ticks(50);
    check_value("t3_busy", st_busy, 32'd0);
    check_value("t3_done", st_done, 32'd0);

    // W=10 G=5 N=4 with retrigger and width change mid-train
    set_cfg(10, 5, 4);
    clr_stats();
    edge_trigger();
    ticks(18);
    trigger_in = 1'b0;
    pulse_width = WB'(2);
    tick();
    trigger_in = 1'b1;
    ticks(70);
    check_value("t4_high", st_high, 32'd40);
    check_value("t4_done", st_done, 32'd1);

    // W=8 N=3: abort in pulse 1, then a normal train
    set_cfg(8, 2, 3);
    clr_stats();
    edge_trigger();
    ticks(3);
    enable = 1'b0;
    tick();
    check_value("t5_abort_pulse", 32'(pulse_out), 32'd0);
    check_value("t5_abort_dbg", 32'(debug[3]), 32'd1);
    ticks(3);
    enable = 1'b1;
    ticks(2);
    clr_stats();
    edge_trigger();
    ticks(40);
    check_value("t5_high", st_high, 32'd24);
    check_value("t5_done", st_done, 32'd1);
    check_value("t5_dbg_clr", 32'(debug[3]), 32'd0);

    // Reset mid-HIGH with trigger held high across release
    set_cfg(6, 3, 2);
    edge_trigger();
    ticks(3);
    reset = 1'b1;
    tick();
    check_value("t6_reset_out", 32'({pulse_out, busy, done, pulse_idx, debug}), 32'd0);
    reset = 1'b0;
    clr_stats();
    ticks(10);
    check_value("t6_held_busy", st_busy, 32'd0);
    clr_stats();
    edge_trigger();
    ticks(25);
    check_value("t6_high", st_high, 32'd12);
    check_value("t6_done", st_done, 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0)
        set_cfg($urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) trigger_in = ~trigger_in;
      enable = ($urandom_range(0, 39) != 0);
      reset  = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    enable = 1'b1;
    ticks(5);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
